muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
Iterative RV32M multiply/divide unit with its own sequencer. It handles every instruction that the control unit flags with RegMul=1 (funct7[0]=1 on OPCODE_REG). While an operation is in flight it holds the core through a stall output, which gates PCEn. When the result is ready it writes rd through its own write port, parallel to the normal RegWrite path.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  RegMul from the control unit; the instruction is present and valid this cycle
funct3  in  3  RV32M operation select
rs1_data  in  XLEN  operand A
rs2_data  in  XLEN  operand B
rd_in  in  5  destination register
kill  in  1  synchronous flush of any in-flight operation
busy  out  1  state is not IDLE
stall  out  1  hold PC/pipeline; the core ANDs ~stall into PCEn
done  out  1  one-cycle result pulse
we  out  1  register-file write enable; equals done
rd_out  out  5  latched rd
result  out  XLEN  latched result; valid while done=1

Behaviour:
- Reset (rst=0, async): state=IDLE; busy, stall, done and we = 0; rd_out and result = 0; internal registers cleared. Reset mid-operation aborts with no write.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE with start=1 and kill=0 (cycle 0) does the following at the edge:
  - Latches funct3 and rd_in.
  - Latches operand magnitudes.
  - Latches the result-sign flags: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
  - Signedness of each operand: MUL/MULH/DIV/REM treat both signed; MULHSU treats A signed, B unsigned; MULHU/DIVU/REMU treat both unsigned.
  - Loads count = XLEN-1.
  - Next state: MUL for funct3 0-3, DIV for funct3 4-7.
- Division special cases (IDLE -> DONE directly, so done is high in cycle 1):
  - Divide by zero (rs2=0): quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient = rs1; remainder = 0.
- MUL: one shift-add step per cycle into a 2*XLEN product register. Exit to FIX when count reaches 0, otherwise decrement count.
- DIV: one restoring-division step per cycle; quotient and remainder each XLEN bits. Exits the same way as MUL.
- FIX: conditionally two's-complement negates the product or the quotient/remainder according to the sign flags, then selects the result:
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Registers result and goes to DONE.
- DONE: done=we=1 for exactly one cycle; stall=0 so the pipeline advances; next state is IDLE.
- Latency: done is high in cycle XLEN+2 (cycle 34 for XLEN=32), except the divide special cases (cycle 1).
- stall = (state==IDLE & start & ~kill) | state∈{MUL,DIV,FIX}. stall is combinational, so the issuing instruction is held starting in cycle 0.
- start is ignored unless the state is IDLE; a second start while busy has no effect.
- Back-to-back operations: a new start in the cycle after DONE is accepted normally.
- kill=1 in any state: next state IDLE, no done/we. kill has priority over start and over the transition to DONE. kill arriving in the DONE cycle does not suppress that done.
- result and rd_out hold their values after done until the next FIX or special case.

Decomposition:
- Package muldiv_pkg holds:
  - The state enum: IDLE, MUL, DIV, FIX, DONE.
  - funct3 constants: F3_MUL=000, F3_MULH=001, F3_MULHSU=010, F3_MULHU=011, F3_DIV=100, F3_DIVU=101, F3_REM=110, F3_REMU=111.
  - The XLEN default.
- One sub-module, muldiv_iter_dp. It contains the product/remainder/quotient shift registers and the add/subtract step, and takes load, step_mul, step_div and negate controls from the sequencer FSM.

Test Plan:
- MUL 7 × 0xFFFFFFFD -> result=0xFFFFFFEB, rd_out=rd_in, done/we high only in cycle 34, stall high cycles 0-33.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2. Each has done in cycle 34.
- Special cases, each with done in cycle 1 and stall only in cycle 0:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- kill in cycle 10 of a MUL -> no done/we, busy=0 in cycle 11; a start in cycle 11 is accepted and completes correctly.
- rst low in cycle 5 of a DIV -> busy, stall and done drop immediately; no write. A start held during busy is ignored, and a start in the cycle after DONE runs a second operation.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_iter_dp.sv
// Shared shift register for shift-add multiply and restoring divide on operand magnitudes.
module muldiv_iter_dp import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step_mul,
  input  logic              step_div,
  input  logic              neg_prod,
  input  logic              neg_quo,
  input  logic              neg_rem,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic [2*XLEN-1:0] prod_fix,
  output logic [XLEN-1:0]   quo_fix,
  output logic [XLEN-1:0]   rem_fix
);

  // Upper half is the partial product / remainder, lower half the multiplier / quotient.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   divisor;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     sub_diff;

  always_comb begin
    add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, divisor} : '0);
    shifted  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    sub_diff = shifted - {1'b0, divisor};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      divisor <= '0;
    end else if (load) begin
      acc     <= {{XLEN{1'b0}}, a_mag};
      divisor <= b_mag;
    end else if (step_mul) begin
      acc <= {add_sum, acc[XLEN-1:1]};
    end else if (step_div) begin
      if (!sub_diff[XLEN])
        acc <= {sub_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc <= {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod_fix = neg_prod ? -acc : acc;
    quo_fix  = neg_quo ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: stalls the core while iterating, then writes rd once.
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            we,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_next;
  logic [2:0]        op;
  logic [4:0]        rd_q;
  logic              neg_prod_q, neg_quo_q, neg_rem_q;
  logic [CW-1:0]     count;

  logic              signed_a, signed_b, sign_a, sign_b;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special, accept;
  logic [XLEN-1:0]   special_result, fix_result;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Operand decode happens on the raw inputs so everything is latched on the accepting edge.
  always_comb begin
    signed_a = (funct3 != F3_MULHU) && (funct3 != F3_DIVU) && (funct3 != F3_REMU);
    signed_b = signed_a && (funct3 != F3_MULHSU);
    sign_a   = signed_a && rs1_data[XLEN-1];
    sign_b   = signed_b && rs2_data[XLEN-1];
    a_mag    = sign_a ? -rs1_data : rs1_data;
    b_mag    = sign_b ? -rs2_data : rs2_data;
    div_zero = funct3[2] && (rs2_data == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
    special  = div_zero || div_ovf;
    if (div_zero)
      special_result = funct3[1] ? rs1_data : '1;
    else
      special_result = funct3[1] ? '0 : rs1_data;
    accept = (state == IDLE) && start && !kill;
  end

  always_comb begin
    fix_result = rem_fix;
    case (op)
      F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              fix_result = quo_fix;
      default:                      fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_next = special ? DONE : (funct3[2] ? DIV : MUL);
        MUL, DIV: if (count == '0) state_next = FIX;
        FIX:      state_next = DONE;
        DONE:     state_next = IDLE;
        default:  state_next = IDLE;
      endcase
    end
    busy  = (state != IDLE);
    stall = accept || (state == MUL) || (state == DIV) || (state == FIX);
    done  = (state == DONE);
    we    = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      op         <= '0;
      rd_q       <= '0;
      neg_prod_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      count      <= '0;
      rd_out     <= '0;
      result     <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        op         <= funct3;
        rd_q       <= rd_in;
        neg_prod_q <= sign_a ^ sign_b;
        neg_quo_q  <= sign_a ^ sign_b;
        neg_rem_q  <= sign_a;
        count      <= CW'(XLEN - 1);
        if (special) begin
          result <= special_result;
          rd_out <= rd_in;
        end
      end
      if (((state == MUL) || (state == DIV)) && (count != '0))
        count <= count - 1'b1;
      if ((state == FIX) && !kill) begin
        result <= fix_result;
        rd_out <= rd_q;
      end
    end
  end

  muldiv_iter_dp #(.XLEN(XLEN)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && !special),
    .step_mul (state == MUL),
    .step_div (state == DIV),
    .neg_prod (neg_prod_q),
    .neg_quo  (neg_quo_q),
    .neg_rem  (neg_rem_q),
    .a_mag    (a_mag),
    .b_mag    (b_mag),
    .prod_fix (prod_fix),
    .quo_fix  (quo_fix),
    .rem_fix  (rem_fix)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed RV32M results and cycle-exact handshakes.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy;
  logic        stall;
  logic        done;
  logic        we;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int assertions = 0;
  int failures   = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .kill     (kill),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .we       (we),
    .rd_out   (rd_out),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge with the unit idle; returns at the negedge of the cycle after done.
  task automatic apply_stimulus(input string name, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                                input int lat, input bit hold);
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    rd_in    = rd;
    start    = 1'b1;
    #1;
    check_output({name, "/stall_c0"}, 32'(stall), 32'd1);
    check_output({name, "/done_c0"}, 32'(done), 32'd0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (hold && c < lat) begin
        start    = 1'b1;
        funct3   = F3_DIVU;
        rs1_data = 32'd0;
        rs2_data = 32'd0;
        rd_in    = 5'd31;
      end else begin
        start = 1'b0;
      end
      #1;
      check_output($sformatf("%s/done_c%0d", name, c), 32'(done), 32'(c == lat));
      check_output($sformatf("%s/stall_c%0d", name, c), 32'(stall), 32'(c < lat));
      if (c == lat) begin
        check_output({name, "/we"}, 32'(we), 32'd1);
        check_output({name, "/result"}, result, exp);
        check_output({name, "/rd_out"}, 32'(rd_out), 32'(rd));
      end
    end
    start = 1'b0;
    @(negedge clk);
    #1;
    check_output({name, "/busy_after"}, 32'(busy), 32'd0);
    check_output({name, "/done_after"}, 32'(done), 32'd0);
    check_output({name, "/result_hold"}, result, exp);
  endtask

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    kill     = 1'b0;
    funct3   = 3'd0;
    rs1_data = 32'd0;
    rs2_data = 32'd0;
    rd_in    = 5'd0;
    repeat (2) @(negedge clk);
    check_output("reset/busy", 32'(busy), 32'd0);
    check_output("reset/stall", 32'(stall), 32'd0);
    check_output("reset/done", 32'(done), 32'd0);
    check_output("reset/we", 32'(we), 32'd0);
    check_output("reset/rd_out", 32'(rd_out), 32'd0);
    check_output("reset/result", result, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    apply_stimulus("MUL",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34, 1'b1);
    apply_stimulus("MULH",   F3_MULH,   32'h8000_0000,  32'h8000_0000, 5'd6,  32'h4000_0000, 34, 1'b0);
    apply_stimulus("MULHU",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 34, 1'b0);
    apply_stimulus("MULHSU", F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         5'd8,  32'hFFFF_FFFF, 34, 1'b0);
    apply_stimulus("DIV",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         5'd9,  32'hFFFF_FFFD, 34, 1'b1);
    apply_stimulus("REM",    F3_REM,    32'hFFFF_FFF9,  32'd2,         5'd10, 32'hFFFF_FFFF, 34, 1'b0);
    apply_stimulus("DIVU",   F3_DIVU,   32'd100,        32'd7,         5'd11, 32'd14,        34, 1'b0);
    apply_stimulus("REMU",   F3_REMU,   32'd100,        32'd7,         5'd12, 32'd2,         34, 1'b0);
    apply_stimulus("DIVU0",  F3_DIVU,   32'd5,          32'd0,         5'd13, 32'hFFFF_FFFF, 1,  1'b0);
    apply_stimulus("REM0",   F3_REM,    32'd5,          32'd0,         5'd14, 32'd5,         1,  1'b0);
    apply_stimulus("DIVOVF", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1,  1'b0);
    apply_stimulus("REMOVF", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'd0,         1,  1'b0);

    // Kill a multiply in its tenth cycle, then issue immediately after.
    funct3   = F3_MUL;
    rs1_data = 32'd3;
    rs2_data = 32'd4;
    rd_in    = 5'd20;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    kill = 1'b1;
    #1;
    check_output("kill/busy_c10", 32'(busy), 32'd1);
    check_output("kill/done_c10", 32'(done), 32'd0);
    @(negedge clk);
    kill = 1'b0;
    #1;
    check_output("kill/busy_c11", 32'(busy), 32'd0);
    check_output("kill/done_c11", 32'(done), 32'd0);
    check_output("kill/we_c11", 32'(we), 32'd0);
    check_output("kill/rd_out_kept", 32'(rd_out), 32'd16);
    apply_stimulus("AFTERKILL", F3_MUL, 32'd12345, 32'd1000, 5'd21, 32'd12345000, 34, 1'b0);

    // Asynchronous reset in the middle of a divide.
    funct3   = F3_DIVU;
    rs1_data = 32'd1000;
    rs2_data = 32'd3;
    rd_in    = 5'd22;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("rstmid/busy", 32'(busy), 32'd0);
    check_output("rstmid/stall", 32'(stall), 32'd0);
    check_output("rstmid/done", 32'(done), 32'd0);
    check_output("rstmid/result", result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      #1;
      check_output($sformatf("rstmid/no_done_%0d", c), 32'(done | we), 32'd0);
    end
    apply_stimulus("AFTERRST", F3_DIVU, 32'd1000, 32'd3, 5'd23, 32'd333, 34, 1'b0);
    apply_stimulus("B2B",      F3_REMU, 32'd1000, 32'd3, 5'd24, 32'd1,   34, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
